// File: rtl/zombie_game_pkg.sv
// Shared types and lane constants for the whack-a-zombie hit detector.
package zombie_game_pkg;

    localparam int unsigned NUM_LANES = 3;

    localparam logic [1:0] LANE_NONE = 2'd0;
    localparam logic [1:0] LANE1     = 2'd1;
    localparam logic [1:0] LANE2     = 2'd2;
    localparam logic [1:0] LANE3     = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REFILL,
        WAIT_HIT,
        RESOLVE,
        OVER
    } state_t;

    typedef enum logic {
        HIT,
        MISS
    } result_t;

    // One-hot press pattern that counts as a hit for the given lane.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] pos);
        case (pos)
            LANE1:   lane_mask = 3'b001;
            LANE2:   lane_mask = 3'b010;
            LANE3:   lane_mask = 3'b100;
            default: lane_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One lane of button conditioning: two-flop synchroniser, stability counter,
// and a one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            press   <= level & ~level_q;
            // Any sample that agrees with the current level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zombie_hit_detector.sv
// Judges debounced lane presses against the displayed zombie; drives the
// picture-advance pulses and keeps score, lives and game-over state.
module zombie_hit_detector
    import zombie_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 200,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn1,
    input  logic               btn2,
    input  logic               btn3,
    input  logic               game_en,
    input  logic               zombie_valid,
    input  logic [1:0]         zombie_pos,
    output logic               need_random,
    output logic               shift,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               gameover
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [NUM_LANES-1:0] btn_raw;
    logic [NUM_LANES-1:0] btn_level;
    logic [NUM_LANES-1:0] btn_press;
    logic [NUM_LANES-1:0] press;

    assign btn_raw = {btn3, btn2, btn1};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[l]),
            .level (btn_level[l]),
            .press (btn_press[l])
        );
    end

    // A press pulse always coincides with a high level; gating keeps both used.
    assign press = btn_press & btn_level;

    state_t          state;
    result_t         res;
    logic [TO_W-1:0] timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            res         <= HIT;
            timeout     <= '0;
            need_random <= 1'b0;
            shift       <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            score       <= '0;
            lives       <= 2'(LIVES);
            gameover    <= 1'b0;
        end else begin
            need_random <= 1'b0;
            shift       <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            case (state)
                IDLE: begin
                    if (game_en) begin
                        need_random <= 1'b1;
                        state       <= REFILL;
                    end
                end
                REFILL: begin
                    if (!game_en) begin
                        state <= IDLE;
                    end else if (zombie_valid && zombie_pos != LANE_NONE) begin
                        timeout <= TO_W'(TIMEOUT_CYCLES - 1);
                        state   <= WAIT_HIT;
                    end
                end
                WAIT_HIT: begin
                    // Result pulses are registered on entry so they appear in RESOLVE.
                    if (!game_en) begin
                        state <= IDLE;
                    end else if (press != '0 && press == lane_mask(zombie_pos)) begin
                        res         <= HIT;
                        hit         <= 1'b1;
                        shift       <= 1'b1;
                        need_random <= 1'b1;
                        state       <= RESOLVE;
                    end else if (press != '0 || timeout == '0) begin
                        res         <= MISS;
                        miss        <= 1'b1;
                        shift       <= (lives != 2'd1);
                        need_random <= (lives != 2'd1);
                        state       <= RESOLVE;
                    end else begin
                        timeout <= timeout - 1'b1;
                    end
                end
                RESOLVE: begin
                    if (res == HIT) begin
                        if (score != '1)
                            score <= score + 1'b1;
                        state <= REFILL;
                    end else begin
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            gameover <= 1'b1;
                            state    <= OVER;
                        end else begin
                            state <= REFILL;
                        end
                    end
                end
                OVER: begin
                    gameover <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zombie_hit_detector.sv
// Directed bench: hits, saturation, timeout boundary, wrong/multi press, game over, resets.
module tb_zombie_hit_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn1, btn2, btn3;
    logic       game_en;
    logic       zombie_valid;
    logic [1:0] zombie_pos;
    logic       need_random, shift, hit, miss;
    logic [1:0] score;
    logic [1:0] lives;
    logic       gameover;

    int n_tests = 0;
    int n_fail  = 0;

    zombie_hit_detector #(
        .DEBOUNCE_CYCLES(16),
        .TIMEOUT_CYCLES (10),
        .LIVES          (3),
        .SCORE_W        (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn1         (btn1),
        .btn2         (btn2),
        .btn3         (btn3),
        .game_en      (game_en),
        .zombie_valid (zombie_valid),
        .zombie_pos   (zombie_pos),
        .need_random  (need_random),
        .shift        (shift),
        .hit          (hit),
        .miss         (miss),
        .score        (score),
        .lives        (lives),
        .gameover     (gameover)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Buttons set after edge e; zombie shown so WAIT_HIT starts at edge e+lead+1;
    // the press is judged at edge e+20 and RESOLVE outputs are visible after it.
    task automatic play(input string tag, input logic [2:0] btns, input logic [1:0] pos,
                        input int lead, input logic exp_hit, input logic exp_shift,
                        input logic [1:0] exp_score, input logic [1:0] exp_lives,
                        input logic exp_over);
        zombie_pos = pos;
        {btn3, btn2, btn1} = btns;
        tick(lead);
        zombie_valid = 1'b1;
        tick(19 - lead);
        check({tag, "_pre"}, {hit, miss}, 2'b00);
        tick(1);
        check({tag, "_hit"}, hit, exp_hit);
        check({tag, "_miss"}, miss, !exp_hit);
        check({tag, "_shift_nr"}, {shift, need_random}, {exp_shift, exp_shift});
        zombie_valid = 1'b0;
        {btn3, btn2, btn1} = 3'b000;
        tick(1);
        check({tag, "_score"}, score, exp_score);
        check({tag, "_lives"}, lives, exp_lives);
        check({tag, "_over"}, gameover, exp_over);
        tick(24);
    endtask

    initial begin
        logic any;
        rst = 1'b0; game_en = 1'b0; zombie_valid = 1'b0; zombie_pos = 2'd0;
        {btn3, btn2, btn1} = 3'b000;
        tick(3);
        check("rst_pulses", {need_random, shift, hit, miss}, 4'b0000);
        check("rst_score", score, 2'd0);
        check("rst_lives", lives, 2'd3);
        check("rst_over", gameover, 1'b0);
        rst = 1'b1;
        tick(2);
        check("idle_pulses", {need_random, shift, hit, miss}, 4'b0000);
        check("idle_lives", lives, 2'd3);

        game_en = 1'b1;
        tick(1);
        check("start_nr", need_random, 1'b1);
        tick(1);
        check("start_nr_off", need_random, 1'b0);

        // Bouncy lane-2 press followed by a stable hold.
        btn2 = 1'b1; tick(2); btn2 = 1'b0; tick(1);
        btn2 = 1'b1; tick(3); btn2 = 1'b0; tick(1);
        play("bouncy_hit", 3'b010, 2'd2, 14, 1'b1, 1'b1, 2'd1, 2'd3, 1'b0);
        play("hit2", 3'b001, 2'd1, 14, 1'b1, 1'b1, 2'd2, 2'd3, 1'b0);
        play("hit3_edge", 3'b100, 2'd3, 9, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0);
        play("hit4_sat", 3'b010, 2'd2, 14, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0);
        play("hit5_sat", 3'b001, 2'd1, 14, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0);

        // 5-cycle glitch is filtered; miss lands exactly on the 10th cycle.
        zombie_pos = 2'd2; zombie_valid = 1'b1;
        tick(1);
        btn2 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 5) btn2 = 1'b0;
            if (i < 10) check("timeout_wait", {hit, miss}, 2'b00);
            else        check("timeout_miss", {hit, miss, shift, need_random}, 4'b0111);
        end
        zombie_valid = 1'b0;
        tick(1);
        check("timeout_lives", lives, 2'd2);
        tick(24);

        play("wrong_lane", 3'b100, 2'd1, 14, 1'b0, 1'b1, 2'd3, 2'd1, 1'b0);
        play("multi_press", 3'b011, 2'd1, 14, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1);

        // Game over ignores further presses.
        any = 1'b0;
        zombie_pos = 2'd1; zombie_valid = 1'b1; btn1 = 1'b1;
        repeat (25) begin
            tick(1);
            any |= hit | miss | shift | need_random;
        end
        check("over_quiet", any, 1'b0);
        check("over_hold", gameover, 1'b1);
        btn1 = 1'b0; zombie_valid = 1'b0; game_en = 1'b0;
        tick(24);

        rst = 1'b0;
        tick(2);
        check("rst2_over", gameover, 1'b0);
        check("rst2_state", {score, lives}, {2'd0, 2'd3});
        rst = 1'b1;
        tick(1);

        // game_en drop in REFILL returns to IDLE, visible as a fresh need_random.
        game_en = 1'b1; tick(1);
        check("restart_nr", need_random, 1'b1);
        game_en = 1'b0; tick(2);
        check("disable_quiet", need_random, 1'b0);
        game_en = 1'b1; tick(1);
        check("reenable_nr", need_random, 1'b1);

        // Reset pulse in WAIT_HIT goes straight to IDLE.
        zombie_pos = 2'd3; zombie_valid = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("midrst_nr", need_random, 1'b0);
        tick(1);
        check("midrst_idle_nr", need_random, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zombie_hit_detector.md
Name: zombie_hit_detector

Overview:
Upstream of the picture-shift stage and the LFSR random generator in the whack-a-zombie matrix game. Conditions the three lane buttons (synchroniser plus debounce) and judges each press against the lane where the zombie is currently up. Produces the `shift` and `need_random` pulses that advance the picture, and maintains score, lives and game-over state. Runs on the game clock domain.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced level changes.
- TIMEOUT_CYCLES, 200: cycles a zombie stays hittable before it counts as a miss.
- LIVES, 3: lives at reset; range 1..3.
- SCORE_W, 8: score counter width.

Ports:
- clk, in, 1: game clock.
- rst, in, 1: reset, synchronous, active-low.
- btn1, in, 1: raw button for lane 1; asynchronous, bouncy.
- btn2, in, 1: raw button for lane 2.
- btn3, in, 1: raw button for lane 3.
- game_en, in, 1: level; 1 = game running.
- zombie_valid, in, 1: level from the picture stage; the new zombie is displayed and zombie_pos is stable.
- zombie_pos, in, 2: lane of the current zombie, 1..3; 0 = none.
- need_random, out, 1: one-cycle pulse requesting a new random lane.
- shift, out, 1: one-cycle pulse telling the picture stage to advance.
- hit, out, 1: one-cycle pulse on a correct hit.
- miss, out, 1: one-cycle pulse on a wrong lane, a multi-press or a timeout.
- score, out, SCORE_W: hit count; saturates at all-ones.
- lives, out, 2: remaining lives.
- gameover, out, 1: level; held until reset.

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-low; all state is sampled on the `clk` edge while rst=0.
- Reset values:
  - state = IDLE
  - need_random = 0, shift = 0, hit = 0, miss = 0
  - score = 0
  - lives = LIVES
  - gameover = 0
  - debounced levels = 0, debounce counters = 0, timeout counter = 0
- Per-button conditioning:
  - Two-flop synchroniser.
  - Debounced level takes the synced value once the synced value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any sample equal to the current debounced level clears the counter.
  - Press event = rising edge of the debounced level; one-cycle pulse.
  - Latency from raw edge to press event: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM:
  - IDLE: when game_en=1, pulse need_random and go to REFILL.
  - REFILL: wait for zombie_valid=1 with zombie_pos≠0. Then load timeout = TIMEOUT_CYCLES-1 and go to WAIT_HIT. If zombie_valid=1 with zombie_pos=0, stay in REFILL.
  - WAIT_HIT: evaluate each cycle, in this priority:
    - Exactly one press event on lane zombie_pos → result = HIT.
    - Any other press pattern (wrong lane, or two or more simultaneous presses) → result = MISS.
    - No press and timeout=0 → result = MISS.
    - Otherwise timeout decrements.
    - A press in the same cycle the timeout reaches 0 is judged as a press.
    - Once a result is set, go to RESOLVE.
  - RESOLVE: exactly one cycle.
    - HIT: hit=1, shift=1, need_random=1 in this cycle; score increments at the end of the cycle, saturating. Next state REFILL.
    - MISS: miss=1 in this cycle; lives decrements at the end of the cycle.
      - If the new lives = 0: next state OVER; no shift or need_random.
      - Otherwise: shift=1 and need_random=1 in this cycle; next state REFILL.
  - OVER: gameover=1, all pulses 0, all press events ignored; stays in OVER until rst.
- Press events outside WAIT_HIT are discarded; they are not queued.
- game_en=0 in REFILL or WAIT_HIT: next state is IDLE; score and lives are kept; no pulse is emitted.
- game_en is not sampled in RESOLVE or OVER.
- Outputs are registered and decoded from state, so there are no combinational paths from inputs to outputs.
- Debounce logic keeps running in every state, so a button held across a state change produces no spurious press.

Decomposition:
- Package `zombie_game_pkg`:
  - State enum: IDLE, REFILL, WAIT_HIT, RESOLVE, OVER.
  - Lane constants: LANE_NONE=0, LANE1..LANE3.
  - Result enum: HIT, MISS.
- Sub-module `btn_debounce` (synchroniser, counter and edge detect; parameter DEBOUNCE_CYCLES; outputs level and press), instantiated three times.
- The FSM, timeout, score and lives logic stays in the top module.

Test Plan:
- Reset, then rst=1 with game_en=0 → all outputs at reset values.
- Raise game_en → need_random pulses in the next cycle. Then drive zombie_pos=2, zombie_valid=1.
- btn2 pulse 5 cycles wide with DEBOUNCE_CYCLES=16 → no press event and no hit.
- Bouncy btn2 press, then held stable for 20 cycles while zombie_pos=2 → one RESOLVE cycle with hit, shift and need_random all 1; score 0→1; lives unchanged.
- zombie_pos=1 and btn3 pressed → miss=1, lives 3→2, shift=1. Separately, btn1 and btn2 debounced in the same cycle → miss.
- No press for TIMEOUT_CYCLES cycles (set to 10) → miss on the expiry boundary. Three consecutive misses → lives reaches 0 and gameover=1; further presses cause no pulses; rst clears gameover.
- Score saturation with SCORE_W=2: 5 hits → score stays at 3.
- Mid-game rst pulse while in WAIT_HIT → FSM returns to IDLE at the next edge.
